// File: rtl/control_register_file_if.sv
// Bus bundle between the core and the control-register file: software
// access, hardware update strobes and the live register/pulse outputs.
interface control_register_file_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 3
);
  logic                   write_enable;
  logic [INDEX_WIDTH-1:0] write_index;
  logic [DATA_WIDTH-1:0]  write_data;
  logic                   read_enable;
  logic [INDEX_WIDTH-1:0] read_index;
  logic [DATA_WIDTH-1:0]  read_data;
  logic                   read_valid;
  logic                   fault_valid;
  logic [DATA_WIDTH-1:0]  fault_linear_address;
  logic                   task_switch_valid;
  logic [DATA_WIDTH-1:0]  task_switch_cr3;
  logic                   clts;
  logic [DATA_WIDTH-1:0]  CR0;
  logic [DATA_WIDTH-1:0]  CR2;
  logic [DATA_WIDTH-1:0]  CR3;
  logic                   tlb_flush;
  logic                   illegal_access;

  modport master (
    output write_enable, write_index, write_data,
    output read_enable, read_index,
    output fault_valid, fault_linear_address,
    output task_switch_valid, task_switch_cr3, clts,
    input  read_data, read_valid, CR0, CR2, CR3, tlb_flush, illegal_access
  );

  modport slave (
    input  write_enable, write_index, write_data,
    input  read_enable, read_index,
    input  fault_valid, fault_linear_address,
    input  task_switch_valid, task_switch_cr3, clts,
    output read_data, read_valid, CR0, CR2, CR3, tlb_flush, illegal_access
  );
endinterface

// File: rtl/control_register_file.sv
// CR0/CR2/CR3 control-register file with registered read port, hardware
// update paths (page fault, task switch, CLTS) and flush/illegal pulses.
module control_register_file #(
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    REG_COUNT       = 8,
  parameter int                    INDEX_WIDTH     = $clog2(REG_COUNT),
  parameter logic [DATA_WIDTH-1:0] CR0_WRITE_MASK  = 32'h8000_001F,
  parameter int                    PAGE_ALIGN_BITS = 12
) (
  input logic                   clock,
  input logic                   reset,
  control_register_file_if.slave bus
);

  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = {DATA_WIDTH{1'b1}} << PAGE_ALIGN_BITS;
  localparam int TS_BIT = 3;
  localparam int PG_BIT = 31;
  localparam int PE_BIT = 0;

  logic [DATA_WIDTH-1:0] cr0_q, cr0_d;
  logic [DATA_WIDTH-1:0] cr2_q, cr2_d;
  logic [DATA_WIDTH-1:0] cr3_q, cr3_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  flush_q, flush_d;
  logic                  illegal_q, illegal_d;

  logic                  wr_reserved;
  logic                  rd_reserved;
  logic                  pg_without_pe;
  logic [DATA_WIDTH-1:0] ts_cr3_aligned;

  function automatic logic is_reserved(input logic [INDEX_WIDTH-1:0] idx);
    return (32'(idx) == 32'd1) || (32'(idx) >= 32'd4);
  endfunction

  always_comb begin
    wr_reserved    = is_reserved(bus.write_index);
    rd_reserved    = is_reserved(bus.read_index);
    pg_without_pe  = bus.write_data[PG_BIT] & ~bus.write_data[PE_BIT];
    ts_cr3_aligned = bus.task_switch_cr3 & ALIGN_MASK;

    cr0_d     = cr0_q;
    cr2_d     = cr2_q;
    cr3_d     = cr3_q;
    rdata_d   = rdata_q;
    rvalid_d  = bus.read_enable;
    flush_d   = 1'b0;
    illegal_d = 1'b0;

    // Reads observe the flop values, so a same-cycle write is not visible yet.
    if (bus.read_enable) begin
      if (rd_reserved) begin
        rdata_d   = '0;
        illegal_d = 1'b1;
      end else if (bus.read_index == INDEX_WIDTH'(0)) begin
        rdata_d = cr0_q;
      end else if (bus.read_index == INDEX_WIDTH'(2)) begin
        rdata_d = cr2_q;
      end else begin
        rdata_d = cr3_q;
      end
    end

    if (bus.write_enable) begin
      if (wr_reserved) begin
        illegal_d = 1'b1;
      end else if (bus.write_index == INDEX_WIDTH'(0)) begin
        if (!bus.task_switch_valid) begin
          if (pg_without_pe) illegal_d = 1'b1;
          else               cr0_d = bus.write_data & CR0_WRITE_MASK;
        end
      end else if (bus.write_index == INDEX_WIDTH'(2)) begin
        cr2_d = bus.write_data;
      end else if (!bus.task_switch_valid) begin
        cr3_d   = bus.write_data & ALIGN_MASK;
        flush_d = 1'b1;
      end
    end

    if (bus.fault_valid) cr2_d = bus.fault_linear_address;

    // CLTS acts after the software write; a task switch then forces TS back on.
    if (bus.clts) cr0_d[TS_BIT] = 1'b0;

    if (bus.task_switch_valid) begin
      cr3_d         = ts_cr3_aligned;
      cr0_d[TS_BIT] = 1'b1;
      flush_d       = (ts_cr3_aligned != cr3_q);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cr0_q     <= '0;
      cr2_q     <= '0;
      cr3_q     <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      flush_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      cr0_q     <= cr0_d;
      cr2_q     <= cr2_d;
      cr3_q     <= cr3_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      flush_q   <= flush_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.CR0            = cr0_q;
  assign bus.CR2            = cr2_q;
  assign bus.CR3            = cr3_q;
  assign bus.read_data      = rdata_q;
  assign bus.read_valid     = rvalid_q;
  assign bus.tlb_flush      = flush_q;
  assign bus.illegal_access = illegal_q;

endmodule

// File: tb/tb_control_register_file.sv
// Randomised bench for control_register_file against an array-based
// architectural model of the control registers, plus directed corner cases.
module tb_control_register_file;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  control_register_file_if #(.DATA_WIDTH(32), .INDEX_WIDTH(3)) bus ();

  control_register_file #(
    .DATA_WIDTH      (32),
    .REG_COUNT       (8),
    .INDEX_WIDTH     (3),
    .CR0_WRITE_MASK  (32'h8000_001F),
    .PAGE_ALIGN_BITS (12)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural model: one slot per index, reserved slots stay 0.
  logic [31:0] m_reg [8];
  logic [31:0] m_rd;
  logic        m_rv;
  logic        m_flush;
  logic        m_ill;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit reserved_idx(input logic [2:0] idx);
    return (idx == 3'd1) || (idx >= 3'd4);
  endfunction

  task automatic clear_inputs();
    rst                      = 1'b0;
    bus.write_enable         = 1'b0;
    bus.write_index          = '0;
    bus.write_data           = '0;
    bus.read_enable          = 1'b0;
    bus.read_index           = '0;
    bus.fault_valid          = 1'b0;
    bus.fault_linear_address = '0;
    bus.task_switch_valid    = 1'b0;
    bus.task_switch_cr3      = '0;
    bus.clts                 = 1'b0;
  endtask

  // Advance one clock: derive the model's next state from current inputs,
  // then compare every output just after the edge.
  task automatic cycle();
    logic [31:0] n_reg [8];
    logic [31:0] n_rd;
    logic        n_rv, n_flush, n_ill;
    logic [31:0] t;
    n_reg   = m_reg;
    n_rd    = m_rd;
    n_rv    = 1'b0;
    n_flush = 1'b0;
    n_ill   = 1'b0;
    if (rst) begin
      foreach (n_reg[i]) n_reg[i] = 32'h0;
      n_rd = 32'h0;
    end else begin
      if (bus.read_enable) begin
        n_rv = 1'b1;
        n_rd = m_reg[bus.read_index];
        if (reserved_idx(bus.read_index)) n_ill = 1'b1;
      end
      if (bus.write_enable) begin
        if (reserved_idx(bus.write_index)) n_ill = 1'b1;
        else if (bus.write_index == 3'd2) n_reg[2] = bus.write_data;
        else if (!bus.task_switch_valid) begin
          if (bus.write_index == 3'd0) begin
            if (bus.write_data[31] && !bus.write_data[0]) n_ill = 1'b1;
            else n_reg[0] = bus.write_data & 32'h8000_001F;
          end else begin
            n_reg[3] = {bus.write_data[31:12], 12'h000};
            n_flush  = 1'b1;
          end
        end
      end
      if (bus.fault_valid) n_reg[2] = bus.fault_linear_address;
      if (bus.clts) n_reg[0] = n_reg[0] & ~32'h8;
      if (bus.task_switch_valid) begin
        t        = {bus.task_switch_cr3[31:12], 12'h000};
        n_flush  = (t != m_reg[3]);
        n_reg[3] = t;
        n_reg[0] = n_reg[0] | 32'h8;
      end
    end
    @(posedge clk);
    #1;
    m_reg   = n_reg;
    m_rd    = n_rd;
    m_rv    = n_rv;
    m_flush = n_flush;
    m_ill   = n_ill;
    check_eq("cr0", bus.CR0, m_reg[0]);
    check_eq("cr2", bus.CR2, m_reg[2]);
    check_eq("cr3", bus.CR3, m_reg[3]);
    check_eq("read_data", bus.read_data, m_rd);
    check_eq("read_valid", 32'(bus.read_valid), 32'(m_rv));
    check_eq("tlb_flush", 32'(bus.tlb_flush), 32'(m_flush));
    check_eq("illegal_access", 32'(bus.illegal_access), 32'(m_ill));
  endtask

  task automatic sw_write(input logic [2:0] idx, input logic [31:0] data);
    bus.write_enable = 1'b1;
    bus.write_index  = idx;
    bus.write_data   = data;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    foreach (m_reg[i]) m_reg[i] = 32'hFFFF_FFFF;
    m_rd = 32'hFFFF_FFFF;
    clear_inputs();
    rst = 1'b1;
    cycle();
    cycle();
    check_eq("reset_cr0", bus.CR0, 32'h0);
    check_eq("reset_flush", 32'(bus.tlb_flush), 32'h0);

    // CR3 load aligns and always flushes, even for an identical value.
    clear_inputs();
    sw_write(3'd3, 32'h1234_5ABC);
    cycle();
    check_eq("cr3_aligned", bus.CR3, 32'h1234_5000);
    check_eq("cr3_flush", 32'(bus.tlb_flush), 32'h1);
    clear_inputs();
    cycle();
    check_eq("flush_single_cycle", 32'(bus.tlb_flush), 32'h0);
    sw_write(3'd3, 32'h1234_5ABC);
    cycle();
    check_eq("cr3_reload_flush", 32'(bus.tlb_flush), 32'h1);

    // CR0 mask and PG-without-PE rejection.
    clear_inputs();
    sw_write(3'd0, 32'hFFFF_FFFF);
    cycle();
    check_eq("cr0_masked", bus.CR0, 32'h8000_001F);
    sw_write(3'd0, 32'h8000_0000);
    cycle();
    check_eq("cr0_pg_no_pe_kept", bus.CR0, 32'h8000_001F);
    check_eq("cr0_pg_no_pe_ill", 32'(bus.illegal_access), 32'h1);

    // Page fault beats a software CR2 write.
    clear_inputs();
    sw_write(3'd2, 32'hAAAA_AAAA);
    bus.fault_valid          = 1'b1;
    bus.fault_linear_address = 32'hDEAD_B000;
    cycle();
    check_eq("fault_over_sw", bus.CR2, 32'hDEAD_B000);
    check_eq("fault_no_ill", 32'(bus.illegal_access), 32'h0);

    // Task switch: flush only on a changed aligned CR3; TS beats CLTS.
    clear_inputs();
    bus.clts = 1'b1;
    sw_write(3'd3, 32'h0001_0000);
    cycle();
    check_eq("clts_clears_ts", bus.CR0 & 32'h8, 32'h0);
    clear_inputs();
    bus.task_switch_valid = 1'b1;
    bus.task_switch_cr3   = 32'h0001_0FFF;
    cycle();
    check_eq("ts_sets_ts", bus.CR0 & 32'h8, 32'h8);
    check_eq("ts_same_no_flush", 32'(bus.tlb_flush), 32'h0);
    bus.task_switch_cr3 = 32'h0002_0000;
    sw_write(3'd0, 32'h0000_0001);
    cycle();
    check_eq("ts_diff_flush", 32'(bus.tlb_flush), 32'h1);
    check_eq("ts_over_cr0_write", bus.CR0, 32'h8000_001F);
    check_eq("ts_drop_no_ill", 32'(bus.illegal_access), 32'h0);
    clear_inputs();
    bus.task_switch_valid = 1'b1;
    bus.task_switch_cr3   = 32'h0002_0000;
    bus.clts              = 1'b1;
    cycle();
    check_eq("ts_beats_clts", bus.CR0 & 32'h8, 32'h8);

    // Reserved reads and read-before-write.
    clear_inputs();
    bus.read_enable = 1'b1;
    bus.read_index  = 3'd1;
    cycle();
    check_eq("rd1_data", bus.read_data, 32'h0);
    check_eq("rd1_ill", 32'(bus.illegal_access), 32'h1);
    bus.read_index = 3'd5;
    cycle();
    check_eq("rd5_valid", 32'(bus.read_valid), 32'h1);
    bus.read_index = 3'd2;
    sw_write(3'd2, 32'h1111_1111);
    cycle();
    check_eq("rbw_old_value", bus.read_data, 32'hDEAD_B000);
    check_eq("rbw_new_cr2", bus.CR2, 32'h1111_1111);
    clear_inputs();
    cycle();
    check_eq("rd_idle_valid", 32'(bus.read_valid), 32'h0);

    // Reset wins over a same-cycle CR3 write and cancels its flush.
    sw_write(3'd3, 32'h5555_5555);
    rst = 1'b1;
    cycle();
    check_eq("rst_cancel_flush", 32'(bus.tlb_flush), 32'h0);
    check_eq("rst_cr3", bus.CR3, 32'h0);

    // Random traffic with sparse hardware events.
    for (int unsigned n = 0; n < 3000; n++) begin
      clear_inputs();
      rst                      = ($urandom_range(63) == 0);
      bus.write_enable         = $urandom_range(1);
      bus.write_index          = 3'($urandom_range(7));
      bus.write_data           = $urandom;
      if ($urandom_range(3) == 0) bus.write_data[31] = ~bus.write_data[0];
      bus.read_enable          = $urandom_range(1);
      bus.read_index           = 3'($urandom_range(7));
      bus.fault_valid          = ($urandom_range(7) == 0);
      bus.fault_linear_address = $urandom;
      bus.task_switch_valid    = ($urandom_range(7) == 0);
      bus.task_switch_cr3      = ($urandom_range(1) == 1) ? (m_reg[3] | 32'(12'($urandom))) : $urandom;
      bus.clts                 = ($urandom_range(5) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
